// File: rtl/au_cmp6_pkg.sv
// Shared types and helpers for the pipelined six-condition comparator.
//   calc_cw      : chunk width, ceil(width / stages)
//   stage_state_t: per-stage state {vld, tc, d, g}; tc is carried for debug visibility only
//   cond_t       : the six condition outputs {lt, gt, eq, le, ge, ne}
//   derive_cond  : decodes the six conditions from the decided/greater flags
package au_cmp6_pkg;

    function automatic int unsigned calc_cw(input int unsigned width, input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

    typedef struct packed {
        logic vld;
        logic tc;
        logic d;
        logic g;
    } stage_state_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic le;
        logic ge;
        logic ne;
    } cond_t;

    function automatic cond_t derive_cond(input logic d, input logic g);
        cond_t c;
        c.gt = d & g;
        c.lt = d & ~g;
        c.eq = ~d;
        c.ge = ~c.lt;
        c.le = ~c.gt;
        c.ne = d;
        return c;
    endfunction

endpackage

// File: rtl/au_cmp6_pipe_if.sv
// Operand/result bundle of au_cmp6_pipe.
//   master: drives en, in_vld, tc, a, b; receives out_vld and lt/gt/eq/le/ge/ne
//   slave : the comparator side
interface au_cmp6_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic             in_vld;
    logic             tc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_vld;
    logic             lt;
    logic             gt;
    logic             eq;
    logic             le;
    logic             ge;
    logic             ne;

    modport master (
        output en, in_vld, tc, a, b,
        input  out_vld, lt, gt, eq, le, ge, ne
    );

    modport slave (
        input  en, in_vld, tc, a, b,
        output out_vld, lt, gt, eq, le, ge, ne
    );
endinterface

// File: rtl/au_cmp6_stage.sv
// One pipeline stage of au_cmp6_pipe: compares chunk IDX (MSB chunk is IDX 0) unless an earlier
// stage already decided, and registers the state plus the operand bits still to be compared.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : clock enable, 0 holds every register
//   st_in/st_out : stage state {vld, tc, d, g} in / registered out
//   a_in/b_in    : padded operands entering this stage
//   a_out/b_out  : registered operands, chunks already consumed cleared to zero
module au_cmp6_stage
    import au_cmp6_pkg::*;
#(
    parameter int unsigned CW     = 8,
    parameter int unsigned STAGES = 4,
    parameter int unsigned IDX    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  stage_state_t         st_in,
    input  logic [STAGES*CW-1:0] a_in,
    input  logic [STAGES*CW-1:0] b_in,
    output stage_state_t         st_out,
    output logic [STAGES*CW-1:0] a_out,
    output logic [STAGES*CW-1:0] b_out
);
    localparam int unsigned PW = STAGES * CW;
    localparam int unsigned Lo = (STAGES - IDX - 1) * CW;
    // Only the bits below this chunk travel on; the rest are constant zero and trim away.
    localparam logic [PW-1:0] KeepMask = (Lo == 0) ? '0 : ({PW{1'b1}} >> (PW - Lo));

    logic [CW-1:0] chunk_a;
    logic [CW-1:0] chunk_b;
    stage_state_t  st_d;
    stage_state_t  st_q;
    logic [PW-1:0] a_q;
    logic [PW-1:0] b_q;

    assign chunk_a = a_in[Lo +: CW];
    assign chunk_b = b_in[Lo +: CW];

    always_comb begin
        st_d = st_in;
        if (!st_in.d) begin
            if (chunk_a > chunk_b) begin
                st_d.d = 1'b1;
                st_d.g = 1'b1;
            end else if (chunk_a < chunk_b) begin
                st_d.d = 1'b1;
                st_d.g = 1'b0;
            end else begin
                st_d.d = 1'b0;
                st_d.g = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (en) begin
            st_q <= st_d;
            a_q  <= a_in & KeepMask;
            b_q  <= b_in & KeepMask;
        end
    end

    assign st_out = st_q;
    assign a_out  = a_q;
    assign b_out  = b_q;
endmodule

// File: rtl/au_cmp6_pipe.sv
// Pipelined WIDTH-bit comparator, unsigned or two's complement per transaction, resolving
// MSB chunk first over STAGES register stages. Latency STAGES enabled cycles, one result per
// enabled cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : au_cmp6_pipe_if.slave (en, in_vld, tc, a, b -> out_vld, lt/gt/eq/le/ge/ne)
// Build option AU_CMP6_PIPE_HOLD_EN: when defined, the condition outputs keep the last valid
// result while out_vld=0; otherwise they read 0 whenever out_vld=0.
module au_cmp6_pipe
    import au_cmp6_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic           clk,
    input logic           rst_n,
    au_cmp6_pipe_if.slave bus
);
    localparam int unsigned CW = calc_cw(WIDTH, STAGES);
    localparam int unsigned PW = STAGES * CW;

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_cmp6_pipe: WIDTH must be at least 1");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $fatal(1, "au_cmp6_pipe: STAGES must lie in 1..WIDTH");
    end

    logic [WIDTH-1:0] msb_flip;
    logic [WIDTH-1:0] a_map;
    logic [WIDTH-1:0] b_map;
    stage_state_t     st  [STAGES+1];
    logic [PW-1:0]    a_p [STAGES+1];
    logic [PW-1:0]    b_p [STAGES+1];
    cond_t            cond_now;
    cond_t            cond_out;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign msb_flip = WIDTH'(bus.tc) << (WIDTH - 1);
    assign a_map    = bus.a ^ msb_flip;
    assign b_map    = bus.b ^ msb_flip;

    // Zero pad lands in the top chunk, equal for both operands.
    assign a_p[0] = PW'(a_map);
    assign b_p[0] = PW'(b_map);
    assign st[0]  = '{vld: bus.in_vld, tc: bus.tc, d: 1'b0, g: 1'b0};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        au_cmp6_stage #(
            .CW     (CW),
            .STAGES (STAGES),
            .IDX    (i)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bus.en),
            .st_in  (st[i]),
            .a_in   (a_p[i]),
            .b_in   (b_p[i]),
            .st_out (st[i+1]),
            .a_out  (a_p[i+1]),
            .b_out  (b_p[i+1])
        );
    end

    assign cond_now = derive_cond(st[STAGES].d, st[STAGES].g);

`ifdef AU_CMP6_PIPE_HOLD_EN
    cond_t hold_q;

    // Captures each valid result as it is presented, so a bubble shows the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (bus.en && st[STAGES].vld) begin
            hold_q <= cond_now;
        end
    end

    assign cond_out = st[STAGES].vld ? cond_now : hold_q;
`else
    assign cond_out = st[STAGES].vld ? cond_now : '0;
`endif

    assign bus.out_vld = st[STAGES].vld;
    assign bus.lt      = cond_out.lt;
    assign bus.gt      = cond_out.gt;
    assign bus.eq      = cond_out.eq;
    assign bus.le      = cond_out.le;
    assign bus.ge      = cond_out.ge;
    assign bus.ne      = cond_out.ne;
endmodule

// File: tb/tb_au_cmp6_pipe.sv
// Directed bench for au_cmp6_pipe: an 8-bit/2-stage instance for latency, signedness, streaming,
// stall and reset, plus a 7-bit/3-stage instance (padded top chunk) fed a mixed stream checked
// against a behavioural compare.
module tb_au_cmp6_pipe;
    localparam int N = 300;
`ifdef AU_CMP6_PIPE_HOLD_EN
    localparam bit Hold = 1'b1;
`else
    localparam bit Hold = 1'b0;
`endif
    // {lt, gt, eq, le, ge, ne}
    localparam logic [5:0] Gt = 6'b010011;
    localparam logic [5:0] Lt = 6'b100101;
    localparam logic [5:0] Eq = 6'b001110;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    au_cmp6_pipe_if #(.WIDTH(8)) b8 ();
    au_cmp6_pipe_if #(.WIDTH(7)) b7 ();

    au_cmp6_pipe #(.WIDTH(8), .STAGES(2)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    au_cmp6_pipe #(.WIDTH(7), .STAGES(3)) u7 (.clk(clk), .rst_n(rst_n), .bus(b7));

    function automatic logic [6:0] obs8();
        return {b8.out_vld, b8.lt, b8.gt, b8.eq, b8.le, b8.ge, b8.ne};
    endfunction

    function automatic logic [6:0] obs7();
        return {b7.out_vld, b7.lt, b7.gt, b7.eq, b7.le, b7.ge, b7.ne};
    endfunction

    function automatic logic [6:0] bub(input logic [5:0] last);
        return {1'b0, (Hold ? last : 6'b0)};
    endfunction

    function automatic logic [5:0] model7(input logic [6:0] x, input logic [6:0] y,
                                          input logic s);
        logic l, g, e;
        if (s) begin
            l = $signed(x) < $signed(y);
            g = $signed(x) > $signed(y);
        end else begin
            l = x < y;
            g = x > y;
        end
        e = (x == y);
        return {l, g, e, ~g, ~l, ~e};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic e, input logic v, input logic s,
                          input logic [7:0] x, input logic [7:0] y);
        b8.en     = e;
        b8.in_vld = v;
        b8.tc     = s;
        b8.a      = x;
        b8.b      = y;
    endtask

    task automatic drive7(input logic v, input logic s, input logic [6:0] x, input logic [6:0] y);
        b7.en     = 1'b1;
        b7.in_vld = v;
        b7.tc     = s;
        b7.a      = x;
        b7.b      = y;
    endtask

    logic [6:0] ra [N];
    logic [6:0] rb [N];
    logic       rt [N];
    logic       rv [N];

    initial begin
        logic [5:0] m;
        logic [5:0] last7;
        logic [2:0] hot;
        int         k;

        rst_n = 1'b0;
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        drive7(1'b0, 1'b0, 7'h00, 7'h00);
        #2;
        check("reset_u8", obs8(), 7'b0);
        check("reset_u7", obs7(), 7'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic unsigned compare, latency 2
        drive8(1'b1, 1'b1, 1'b0, 8'hA5, 8'hA3);
        tick();
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("a5a3_lat1", obs8(), 7'b0);
        tick();
        check("a5a3_gt", obs8(), {1'b1, Gt});
        tick();
        check("bubble_after_gt", obs8(), bub(Gt));

        // Same operands, signed then unsigned
        drive8(1'b1, 1'b1, 1'b1, 8'h80, 8'h7F);
        tick();
        drive8(1'b1, 1'b1, 1'b0, 8'h80, 8'h7F);
        tick();
        check("signed_lt", obs8(), {1'b1, Lt});
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("unsigned_gt", obs8(), {1'b1, Gt});
        tick();
        check("bubble_after_sign", obs8(), bub(Gt));

        // Back-to-back stream
        drive8(1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C);
        tick();
        drive8(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
        tick();
        check("stream_eq", obs8(), {1'b1, Eq});
        drive8(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
        tick();
        check("stream_lt", obs8(), {1'b1, Lt});
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("stream_gt", obs8(), {1'b1, Gt});
        tick();
        check("stream_drain", obs8(), bub(Gt));

        // Stall for three cycles with a second transaction in flight
        drive8(1'b1, 1'b1, 1'b0, 8'hA5, 8'hA3);
        tick();
        drive8(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
        tick();
        check("stall_pre", obs8(), {1'b1, Gt});
        drive8(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_frozen%0d", i), obs8(), {1'b1, Gt});
        end
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check("stall_resume_lt", obs8(), {1'b1, Lt});
        tick();
        check("stall_drain", obs8(), bub(Lt));
        tick();
        check("stall_no_ghost", obs8(), bub(Lt));

        // Asynchronous reset with two transactions in flight
        drive8(1'b1, 1'b1, 1'b0, 8'hA5, 8'hA3);
        tick();
        drive8(1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C);
        tick();
        check("rst_pre", obs8(), {1'b1, Gt});
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", obs8(), 7'b0);
        tick();
        check("rst_held", obs8(), 7'b0);
        rst_n = 1'b1;
        tick();
        check("rst_no_stale1", obs8(), 7'b0);
        tick();
        check("rst_no_stale2", obs8(), 7'b0);
        drive8(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF);
        tick();
        drive8(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("post_rst_lat1", obs8(), 7'b0);
        tick();
        check("post_rst_lt", obs8(), {1'b1, Lt});

        // 7-bit / 3-stage: directed sign-boundary vectors, then a mixed stream with bubbles
        ra[0] = 7'h40; rb[0] = 7'h3F; rt[0] = 1'b1; rv[0] = 1'b1;
        ra[1] = 7'h40; rb[1] = 7'h3F; rt[1] = 1'b0; rv[1] = 1'b1;
        ra[2] = 7'h7F; rb[2] = 7'h7F; rt[2] = 1'b1; rv[2] = 1'b1;
        ra[3] = 7'h7F; rb[3] = 7'h00; rt[3] = 1'b1; rv[3] = 1'b1;
        for (int i = 4; i < N; i++) begin
            ra[i] = 7'($urandom_range(0, 127));
            rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 7'($urandom_range(0, 127));
            rt[i] = 1'($urandom_range(0, 1));
            rv[i] = ($urandom_range(0, 3) != 0);
        end
        last7 = 6'b0;
        for (int n = 0; n < N + 2; n++) begin
            if (n < N) drive7(rv[n], rt[n], ra[n], rb[n]);
            else drive7(1'b0, 1'b0, 7'h00, 7'h00);
            tick();
            if (n >= 2) begin
                k = n - 2;
                if (rv[k]) begin
                    m = model7(ra[k], rb[k], rt[k]);
                    check($sformatf("w7_vec%0d", k), obs7(), {1'b1, m});
                    hot = 3'(b7.lt) + 3'(b7.gt) + 3'(b7.eq);
                    check($sformatf("w7_onehot%0d", k), {4'b0, hot}, 7'd1);
                    last7 = m;
                end else begin
                    check($sformatf("w7_bubble%0d", k), obs7(), bub(last7));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
